// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } seq_state_e;

    // LSB of port `port` inside a flattened bus of `width`-bit lanes.
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps every register to zero after reset or on request,
// then holds Ready high until the next request.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ClearReq,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              Ready
);

    seq_state_e        r_state;
    logic [ADDR_W-1:0] r_count;

    // Sweep one register per edge; all-ones count is the last one, no wrap.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_CLEAR;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_count == '1) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (ClearReq) begin
                        r_state <= ST_CLEAR;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign clr_we   = (r_state == ST_CLEAR);
    assign clr_addr = r_count;
    assign Ready    = (r_state == ST_IDLE);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ combinational reads, two prioritised
// write ports with optional write-first bypass and hardwired zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_READ = 2,
    parameter bit          HAS_ZERO = 1'b1,
    parameter int unsigned ZERO_REG = 31,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [NUM_READ*ADDR_W-1:0]   RA,
    output logic [NUM_READ*DATA_W-1:0]   BusR,
    input  logic [ADDR_W-1:0]            RW0,
    input  logic [ADDR_W-1:0]            RW1,
    input  logic [DATA_W-1:0]            BusW0,
    input  logic [DATA_W-1:0]            BusW1,
    input  logic                         RegWr0,
    input  logic                         RegWr1,
    input  logic                         ClearReq,
    output logic                         Ready,
    output logic                         WrConflict
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_wr_conflict;

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_ready;
    logic [ADDR_W-1:0] w_zero_addr;
    logic              w_we0;
    logic              w_we1;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .Clk      (Clk),
        .Reset    (Reset),
        .ClearReq (ClearReq),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .Ready    (w_ready)
    );

    assign w_zero_addr = ADDR_W'(ZERO_REG);
    assign w_we0 = RegWr0 && !(HAS_ZERO && (RW0 == w_zero_addr));
    assign w_we1 = RegWr1 && !(HAS_ZERO && (RW1 == w_zero_addr));

    // Array has no reset; sweep beats port 1, port 1 beats port 0.
    always_ff @(posedge Clk) begin
        if (w_clr_we) begin
            r_regs[w_clr_addr] <= '0;
        end else begin
            if (w_we0) begin
                r_regs[RW0] <= BusW0;
            end
            if (w_we1) begin
                r_regs[RW1] <= BusW1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_conflict <= 1'b0;
        end else begin
            r_wr_conflict <= w_ready && w_we0 && w_we1 && (RW0 == RW1);
        end
    end

    assign Ready      = w_ready;
    assign WrConflict = r_wr_conflict;

    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
        localparam int unsigned RA_LSB = port_lsb(gi, ADDR_W);
        localparam int unsigned RD_LSB = port_lsb(gi, DATA_W);

        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = RA[RA_LSB +: ADDR_W];

        // Read priority: not ready, zero register, port 1 bypass, port 0 bypass, array.
        always_comb begin
            w_rd = r_regs[w_ra];
            if (!w_ready) begin
                w_rd = '0;
            end else if (HAS_ZERO && (w_ra == w_zero_addr)) begin
                w_rd = '0;
            end else if (BYPASS && RegWr1 && (RW1 == w_ra)) begin
                w_rd = BusW1;
            end else if (BYPASS && RegWr0 && (RW0 == w_ra)) begin
                w_rd = BusW0;
            end
        end

        assign BusR[RD_LSB +: DATA_W] = w_rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table plus sweep/reset sequences,
// expected values queued in a scoreboard and popped at sample time.
module tb_regfile_mp;

    localparam int unsigned DEPTH = 32;

    logic         Clk;
    logic         Reset;
    logic [4:0]   ra0, ra1;
    logic [9:0]   RA;
    logic [127:0] BusR;
    logic [4:0]   RW0, RW1;
    logic [63:0]  BusW0, BusW1;
    logic         RegWr0, RegWr1, ClearReq;
    logic         Ready, WrConflict;

    assign RA = {ra1, ra0};

    regfile_mp dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .RA         (RA),
        .BusR       (BusR),
        .RW0        (RW0),
        .RW1        (RW1),
        .BusW0      (BusW0),
        .BusW1      (BusW1),
        .RegWr0     (RegWr0),
        .RegWr1     (RegWr1),
        .ClearReq   (ClearReq),
        .Ready      (Ready),
        .WrConflict (WrConflict)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        we0;
        logic [4:0]  rw0;
        logic [63:0] bw0;
        logic        we1;
        logic [4:0]  rw1;
        logic [63:0] bw1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] exp0;
        logic [63:0] exp1;
        logic        exp_conf;
    } vec_t;
    vec_t vecs[12];

    logic [63:0] m_regs[DEPTH];

    task automatic expect_val(input string name, input logic [63:0] v);
        sb_t e;
        e.name = name;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic check_act(input logic [63:0] act);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty actual=%h required=<queued value>", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        RegWr0 = 1'b0; RegWr1 = 1'b0; ClearReq = 1'b0;
        RW0 = '0; RW1 = '0; BusW0 = '0; BusW1 = '0;
    endtask

    // Counts edges until Ready rises (bounded); flags stay quiet meanwhile.
    task automatic wait_ready(input string tag);
        int edges;
        edges = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge Clk);
            #1;
            expect_val({tag, "_conf_in_sweep"}, 64'd0);
            check_act({63'd0, WrConflict});
            if (Ready) begin
                edges = e;
                break;
            end
            expect_val({tag, "_busr_in_sweep"}, 64'd0);
            check_act(BusR[63:0]);
        end
        expect_val({tag, "_ready_edges"}, 64'd32);
        check_act(64'(edges));
    endtask

    task automatic read_all(input string tag);
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            ra0 = 5'(2 * k);
            ra1 = 5'(2 * k + 1);
            expect_val($sformatf("%s_r%0d", tag, 2 * k), m_regs[2 * k]);
            expect_val($sformatf("%s_r%0d", tag, 2 * k + 1), m_regs[2 * k + 1]);
            #2;
            check_act(BusR[63:0]);
            check_act(BusR[127:64]);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 64'd0, 5'd5, 5'd6, 64'hDEAD_BEEF, 64'd0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 64'd2, 5'd7, 5'd5, 64'd2, 64'hDEAD_BEEF, 1'b1};
        vecs[3]  = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd31, 64'd2, 64'd0, 1'b0};
        vecs[4]  = '{1'b1, 5'd31, 64'h1234, 1'b0, 5'd0, 64'd0, 5'd31, 5'd7, 64'd0, 64'd2, 1'b0};
        vecs[5]  = '{1'b1, 5'd31, 64'd5, 1'b1, 5'd31, 64'd6, 5'd31, 5'd31, 64'd0, 64'd0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd0, 64'd0, 64'd0, 1'b0};
        vecs[7]  = '{1'b1, 5'd3, 64'hAAAA, 1'b1, 5'd4, 64'hBBBB, 5'd4, 5'd3, 64'hBBBB, 64'hAAAA, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'hCCCC, 5'd3, 5'd4, 64'hCCCC, 64'hBBBB, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4, 64'hCCCC, 64'hBBBB, 1'b0};
        vecs[10] = '{1'b1, 5'd4, 64'hDDDD, 1'b1, 5'd3, 64'hEEEE, 5'd4, 5'd3, 64'hDDDD, 64'hEEEE, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd4, 5'd3, 64'hDDDD, 64'hEEEE, 1'b0};

        for (int i = 0; i < DEPTH; i++) m_regs[i] = 64'd0;

        // Reset state
        idle_inputs();
        ra0 = 5'd5; ra1 = 5'd0;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        expect_val("rst_ready", 64'd0);       check_act({63'd0, Ready});
        expect_val("rst_conflict", 64'd0);    check_act({63'd0, WrConflict});
        expect_val("rst_busr", 64'd0);        check_act(BusR[63:0]);
        @(negedge Clk);
        Reset = 1'b0;
        wait_ready("rst");
        read_all("post_rst");

        // Table-driven IDLE vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            RegWr0 = vecs[i].we0; RW0 = vecs[i].rw0; BusW0 = vecs[i].bw0;
            RegWr1 = vecs[i].we1; RW1 = vecs[i].rw1; BusW1 = vecs[i].bw1;
            ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
            expect_val($sformatf("vec%0d_rd0", i), vecs[i].exp0);
            expect_val($sformatf("vec%0d_rd1", i), vecs[i].exp1);
            #2;
            check_act(BusR[63:0]);
            check_act(BusR[127:64]);
            @(posedge Clk);
            #1;
            expect_val($sformatf("vec%0d_conf", i), 64'(vecs[i].exp_conf));
            check_act({63'd0, WrConflict});
        end

        // Fill 0..30 with distinct nonzero data
        for (int i = 0; i < 31; i++) begin
            @(negedge Clk);
            idle_inputs();
            RegWr0 = 1'b1;
            RW0 = 5'(i);
            BusW0 = {32'(i + 1), 32'hA5A5_5A5A};
            m_regs[i] = BusW0;
        end
        @(negedge Clk);
        idle_inputs();
        read_all("filled");

        // ClearReq with a same-cycle write, then writes during sweep
        @(negedge Clk);
        ClearReq = 1'b1;
        RegWr0 = 1'b1; RW0 = 5'd0; BusW0 = 64'h5555;
        @(posedge Clk);
        #1;
        expect_val("clr_ready_drop", 64'd0);
        check_act({63'd0, Ready});
        @(negedge Clk);
        ClearReq = 1'b0;
        RegWr0 = 1'b1; RW0 = 5'd1; BusW0 = 64'hFF;
        RegWr1 = 1'b1; RW1 = 5'd1; BusW1 = 64'hEE;
        ra0 = 5'd1;
        wait_ready("clr");
        @(negedge Clk);
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) m_regs[i] = 64'd0;
        read_all("post_clr");

        // Reset in the middle of a sweep restarts it
        for (int i = 10; i < 14; i++) begin
            @(negedge Clk);
            RegWr0 = 1'b1; RW0 = 5'(i); BusW0 = 64'(i) << 8;
        end
        @(negedge Clk);
        idle_inputs();
        ClearReq = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        ClearReq = 1'b0;
        repeat (10) @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        expect_val("midrst_ready", 64'd0);
        check_act({63'd0, Ready});
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        wait_ready("midrst");
        read_all("post_midrst");

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the single-cycle datapath and its pipelined successor. It has a configurable data width and depth, NUM_READ combinational read ports, and two prioritised write ports with write-first bypass. A hardwired zero register is optional. A built-in clear sequencer sweeps every register to zero after reset or on request, and `Ready` signals when the array is valid. A registered conflict flag reports same-address dual writes.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
- NUM_READ, 2, number of read ports (1..4)
- HAS_ZERO, 1, when 1 register ZERO_REG reads as 0 and ignores writes
- ZERO_REG, 31, index of the hardwired zero register
- BYPASS, 1, when 1 same-cycle writes are forwarded to matching reads

Ports:
- Clk  input  1  sole clock; all state changes on rising edge
- Reset  input  1  asynchronous, active-high; resets sequencer, Ready, WrConflict (not array contents)
- RA  input  NUM_READ*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- BusR  output  NUM_READ*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- RW0, RW1  input  ADDR_W each  write addresses
- BusW0, BusW1  input  DATA_W each  write data
- RegWr0, RegWr1  input  1 each  write enables
- ClearReq  input  1  single-cycle request to re-zero the whole array
- Ready  output  1  high when array is valid and writes are accepted
- WrConflict  output  1  registered pulse: previous cycle had both ports writing the same non-zero register

## Operation
- Sequencer states: CLEAR, IDLE. Reset forces CLEAR with counter = 0.
- CLEAR: each rising edge writes 0 to register[counter], then counter+1.
  - At counter = DEPTH-1 the write occurs and state moves to IDLE.
  - RegWr0/RegWr1 are ignored; ClearReq is ignored (no restart).
- IDLE: a write port commits BusWn to register[RWn] on the rising edge when RegWrn = 1.
  - RegWr to ZERO_REG is dropped when HAS_ZERO = 1.
- Dual write to the same address: port 1 wins. WrConflict = 1 on the following cycle for exactly one cycle. It is not set for ZERO_REG or during CLEAR.
- ClearReq = 1 in IDLE: enter CLEAR with counter = 0. Writes in that same cycle still commit, then get overwritten by the sweep.
- Read port i, combinational, priority order:
  1. Ready = 0 → 0.
  2. HAS_ZERO and RA_i = ZERO_REG → 0.
  3. BYPASS and RegWr1 and RW1 = RA_i → BusW1.
  4. BYPASS and RegWr0 and RW0 = RA_i → BusW0.
  5. Otherwise → register[RA_i].
- Ready = (state == IDLE), registered.
- Reset values: Ready = 0, WrConflict = 0, state = CLEAR, counter = 0. BusR = 0 while Ready = 0.

## Timing
- Read latency 0 cycles (combinational); write-to-read visibility is next cycle, or same cycle through bypass.
- Reset is asserted asynchronously. Deassertion is sampled on the next rising edge.
- Clear sweep takes exactly DEPTH rising edges after reset release or ClearReq. Ready rises on the edge that writes register[DEPTH-1].
- Reset asserted mid-sweep restarts the sweep at counter 0. Registers already cleared stay 0; other contents are undefined until swept.
- Counter width is ADDR_W. Terminal detection uses the all-ones comparison, with no wrap past DEPTH-1.
- Array has no reset so it infers as distributed RAM. Only the sequencer and flags are asynchronously reset.

## Structure
- Package regfile_pkg:
  - state encoding constants ST_CLEAR = 1'b0, ST_IDLE = 1'b1
  - helper functions for slicing flattened RA/BusR buses
- Sub-module regfile_clear_seq: the FSM and sweep counter.
  - Inputs: Clk, Reset, ClearReq.
  - Outputs: clr_we, clr_addr, Ready.
- Top module: array, write muxing (sweep > port 1 > port 0), bypass/zero read logic, WrConflict register.

## Test plan
- Reset pulse, DEPTH=32 → Ready low for 32 rising edges, high on the 32nd. All 32 registers read 0.
- IDLE, RegWr0 RW0=5 BusW0=64'hDEAD_BEEF, RA[0]=5 same cycle → BusR[0] = DEAD_BEEF immediately (bypass). After the edge, with RegWr0=0, it is still DEAD_BEEF.
- RegWr0 and RegWr1 both to RW=7, BusW0=1, BusW1=2 → register 7 = 2. WrConflict = 1 for exactly the next cycle.
- Write 64'h1234 to RW0=31 → BusR for RA=31 stays 0 before and after; WrConflict stays 0 on a dual write to 31.
- After filling registers 0..30 with nonzero data, pulse ClearReq → Ready low for 32 cycles and RegWr during the sweep is ignored. Afterwards all registers read 0.
- Assert Reset at sweep counter 10 → Ready stays 0 and the sweep restarts. Ready rises 32 edges after Reset release.
